// File: rtl/ds_temp_ctrl_pkg.sv
// Shared constants for the DS18B20 measurement sequencer: 1-wire command bytes,
// FSM state encoding and the default conversion wait.
package ds_temp_ctrl_pkg;

  localparam logic [7:0] CMD_SKIP_ROM = 8'hCC;
  localparam logic [7:0] CMD_CONVERT  = 8'h44;
  localparam logic [7:0] CMD_READ_SP  = 8'hBE;

  localparam int CONV_CYCLES_DEF = 37_500_000;

  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_RST1   = 4'd1,
    ST_SKIP1  = 4'd2,
    ST_CONV   = 4'd3,
    ST_WAIT   = 4'd4,
    ST_RST2   = 4'd5,
    ST_SKIP2  = 4'd6,
    ST_RDCMD  = 4'd7,
    ST_RD_LSB = 4'd8,
    ST_RD_MSB = 4'd9,
    ST_DONE   = 4'd10
  } state_e;

endpackage

// File: rtl/ds_temp_ctrl.sv
// DS18B20 command sequencer: drives the byte-level 1-wire layer through one full
// convert-and-read transaction per start pulse and presents the raw temperature word.
module ds_temp_ctrl
  import ds_temp_ctrl_pkg::*;
#(
  parameter int CONV_CYCLES = CONV_CYCLES_DEF,
  parameter int CNT_W       = 26
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  output logic        busy,
  output logic        rst_en,
  output logic        wr_en,
  output logic [7:0]  wdata,
  output logic        rd_en,
  input  logic [7:0]  rdata,
  input  logic        rdata_vld,
  input  logic        rdy,
  output logic [15:0] temp,
  output logic        temp_vld
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(CONV_CYCLES - 1);

  state_e           state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             req_sent_q, req_sent_d;
  logic [7:0]       lsb_q, lsb_d;
  logic             busy_q, busy_d;
  logic             rst_en_q, rst_en_d;
  logic             wr_en_q, wr_en_d;
  logic             rd_en_q, rd_en_d;
  logic [7:0]       wdata_q, wdata_d;
  logic [15:0]      temp_q, temp_d;
  logic             temp_vld_q, temp_vld_d;

  logic pulse_hi;
  logic can_issue;
  logic wr_done;
  logic rd_done;

  // A new request needs a free byte layer and no pulse still in flight; a write or
  // reset completes once the layer reports ready again after the pulse.
  assign pulse_hi  = rst_en_q | wr_en_q | rd_en_q;
  assign can_issue = !req_sent_q && rdy && !pulse_hi;
  assign wr_done   = req_sent_q && !pulse_hi && rdy;
  assign rd_done   = req_sent_q && rdata_vld;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    req_sent_d = req_sent_q;
    lsb_d      = lsb_q;
    rst_en_d   = 1'b0;
    wr_en_d    = 1'b0;
    rd_en_d    = 1'b0;
    wdata_d    = wdata_q;
    temp_d     = temp_q;
    temp_vld_d = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) state_d = ST_RST1;
      end
      ST_RST1, ST_RST2: begin
        if (can_issue) begin
          rst_en_d   = 1'b1;
          req_sent_d = 1'b1;
        end else if (wr_done) begin
          req_sent_d = 1'b0;
          state_d    = (state_q == ST_RST1) ? ST_SKIP1 : ST_SKIP2;
        end
      end
      ST_SKIP1, ST_SKIP2, ST_CONV, ST_RDCMD: begin
        if (can_issue) begin
          wr_en_d    = 1'b1;
          req_sent_d = 1'b1;
          unique case (state_q)
            ST_CONV:  wdata_d = CMD_CONVERT;
            ST_RDCMD: wdata_d = CMD_READ_SP;
            default:  wdata_d = CMD_SKIP_ROM;
          endcase
        end else if (wr_done) begin
          req_sent_d = 1'b0;
          unique case (state_q)
            ST_SKIP1: state_d = ST_CONV;
            ST_CONV:  state_d = ST_WAIT;
            ST_SKIP2: state_d = ST_RDCMD;
            default:  state_d = ST_RD_LSB;
          endcase
        end
      end
      ST_WAIT: begin
        if (cnt_q == CNT_LAST) begin
          cnt_d   = '0;
          state_d = ST_RST2;
        end else begin
          cnt_d = cnt_q + 1'b1;
        end
      end
      ST_RD_LSB, ST_RD_MSB: begin
        if (can_issue) begin
          rd_en_d    = 1'b1;
          req_sent_d = 1'b1;
        end else if (rd_done) begin
          req_sent_d = 1'b0;
          if (state_q == ST_RD_LSB) begin
            lsb_d   = rdata;
            state_d = ST_RD_MSB;
          end else begin
            temp_d     = {rdata, lsb_q};
            temp_vld_d = 1'b1;
            state_d    = ST_DONE;
          end
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      req_sent_q <= 1'b0;
      lsb_q      <= '0;
      busy_q     <= 1'b0;
      rst_en_q   <= 1'b0;
      wr_en_q    <= 1'b0;
      rd_en_q    <= 1'b0;
      wdata_q    <= '0;
      temp_q     <= '0;
      temp_vld_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      req_sent_q <= req_sent_d;
      lsb_q      <= lsb_d;
      busy_q     <= busy_d;
      rst_en_q   <= rst_en_d;
      wr_en_q    <= wr_en_d;
      rd_en_q    <= rd_en_d;
      wdata_q    <= wdata_d;
      temp_q     <= temp_d;
      temp_vld_q <= temp_vld_d;
    end
  end

  assign busy     = busy_q;
  assign rst_en   = rst_en_q;
  assign wr_en    = wr_en_q;
  assign rd_en    = rd_en_q;
  assign wdata    = wdata_q;
  assign temp     = temp_q;
  assign temp_vld = temp_vld_q;

endmodule

// File: tb/tb_ds_temp_ctrl.sv
// Bench for ds_temp_ctrl: behavioural 1-wire byte layer with random latency, a
// request log compared against the expected DS18B20 command sequence.
module tb_ds_temp_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        start;
  logic        busy;
  logic        rst_en;
  logic        wr_en;
  logic [7:0]  wdata;
  logic        rd_en;
  logic [7:0]  rdata;
  logic        rdata_vld;
  logic        rdy;
  logic [15:0] temp;
  logic        temp_vld;

  always #5 clk = ~clk;

  ds_temp_ctrl #(.CONV_CYCLES(100), .CNT_W(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .busy      (busy),
    .rst_en    (rst_en),
    .wr_en     (wr_en),
    .wdata     (wdata),
    .rd_en     (rd_en),
    .rdata     (rdata),
    .rdata_vld (rdata_vld),
    .rdy       (rdy),
    .temp      (temp),
    .temp_vld  (temp_vld)
  );

  int n_cmp  = 0;
  int n_fail = 0;

  // Byte-layer model: every request keeps the layer busy for 1..lat_max+1 cycles;
  // a read ends with a one-cycle rdata_vld carrying the next scratchpad byte.
  int         lat_max = 0;
  logic [7:0] lsb_b, msb_b;
  int         bl_cnt;
  logic       pend_rd, rd_idx, m_vld;
  logic [7:0] m_rdata;
  logic       spur_vld;
  logic [7:0] spur_data;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bl_cnt  <= 0;
      pend_rd <= 1'b0;
      rd_idx  <= 1'b0;
      m_vld   <= 1'b0;
      m_rdata <= 8'h00;
    end else begin
      m_vld <= 1'b0;
      if (rst_en | wr_en | rd_en) begin
        bl_cnt  <= 1 + int'($urandom_range(lat_max, 0));
        pend_rd <= rd_en;
        if (rst_en) rd_idx <= 1'b0;
      end else if (bl_cnt != 0) begin
        bl_cnt <= bl_cnt - 1;
        if (bl_cnt == 1 && pend_rd) begin
          m_vld   <= 1'b1;
          m_rdata <= rd_idx ? msb_b : lsb_b;
          rd_idx  <= ~rd_idx;
        end
      end
    end
  end

  assign rdy       = (bl_cnt == 0) && !(rst_en | wr_en | rd_en);
  assign rdata_vld = m_vld | spur_vld;
  assign rdata     = spur_vld ? spur_data : m_rdata;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Request log: 256 = 1-wire reset, 512 = byte read, otherwise the written byte.
  int req_log[$];
  int exp_seq[8] = '{256, 'hCC, 'h44, 256, 'hCC, 'hBE, 512, 512};
  int viol, tv_cnt, tv_cyc, last_rvld_cyc, conv_end_cyc, rst2_cyc;
  bit after44, prev_rdy, prev_pulse;

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        after44    = 0;
        prev_rdy   = 0;
        prev_pulse = 0;
      end else begin
        if (rst_en | wr_en | rd_en) begin
          int code;
          if (!prev_rdy || prev_pulse) viol++;
          if ((int'(rst_en) + int'(wr_en) + int'(rd_en)) > 1) viol++;
          code = rst_en ? 256 : (wr_en ? int'(wdata) : 512);
          if (rst_en && req_log.size() == 3) rst2_cyc = cyc;
          if (wr_en && wdata == 8'h44) after44 = 1;
          req_log.push_back(code);
        end else if (after44 && rdy) begin
          conv_end_cyc = cyc;
          after44      = 0;
        end
        if (m_vld) last_rvld_cyc = cyc;
        if (temp_vld) begin
          tv_cnt++;
          tv_cyc = cyc;
        end
        prev_rdy   = rdy;
        prev_pulse = rst_en | wr_en | rd_en;
      end
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, got no end, required summary");
    $fatal(1);
  end

  function automatic int seq_errors();
    int e = 0;
    if (req_log.size() != 8) return 99;
    for (int i = 0; i < 8; i++) if (req_log[i] != exp_seq[i]) e++;
    return e;
  endfunction

  task automatic clear_mon();
    req_log.delete();
    viol          = 0;
    tv_cnt        = 0;
    tv_cyc        = -1;
    last_rvld_cyc = -1000;
    conv_end_cyc  = -1;
    rst2_cyc      = -1;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic wait_tv(input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (temp_vld) begin
        ok = 1;
        break;
      end
    end
    #1;
  endtask

  task automatic wait_log(input int n, input int budget, output bit ok);
    ok = 0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (req_log.size() >= n) begin
        ok = 1;
        break;
      end
    end
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({busy, rst_en, wr_en, rd_en, temp_vld} !== 5'b0)
      begin n_fail++; $display("FAIL reset_ctrl: got %b, want 00000", {busy, rst_en, wr_en, rd_en, temp_vld}); end
    n_cmp++;
    if ({wdata, temp} !== 24'h0)
      begin n_fail++; $display("FAIL reset_data: got %h, want 000000", {wdata, temp}); end
    rst_n = 1'b1;
    repeat (5) @(negedge clk);
    n_cmp++;
    if ({busy, rst_en, wr_en, rd_en} !== 4'b0)
      begin n_fail++; $display("FAIL idle_no_start: got %b, want 0000", {busy, rst_en, wr_en, rd_en}); end
  endtask

  task automatic test_basic();
    bit ok;
    lat_max = 0; lsb_b = 8'h91; msb_b = 8'h01;
    clear_mon();
    pulse_start();
    n_cmp++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy: got %b, want 1", busy); end
    wait_tv(3000, ok);
    n_cmp++;
    if (ok !== 1'b1) begin n_fail++; $display("FAIL basic_timeout: got no temp_vld, want one"); end
    n_cmp++;
    if (temp !== 16'h0191) begin n_fail++; $display("FAIL basic_temp: got %h, want 0191", temp); end
    n_cmp++;
    if (seq_errors() !== 0) begin n_fail++; $display("FAIL basic_seq: got %0d errors over %0d requests, want 0", seq_errors(), req_log.size()); end
    n_cmp++;
    if (tv_cyc - last_rvld_cyc !== 1)
      begin n_fail++; $display("FAIL basic_latency: got %0d cycles after MSB, want 1", tv_cyc - last_rvld_cyc); end
    // 100 WAIT cycles plus the RST2 issue cycle after the edge that leaves CONV;
    // rst_en then shows up one sample later.
    n_cmp++;
    if (rst2_cyc - conv_end_cyc !== 102)
      begin n_fail++; $display("FAIL conv_wait: got %0d, want 102", rst2_cyc - conv_end_cyc); end
    repeat (5) @(negedge clk);
    n_cmp++;
    if (tv_cnt !== 1) begin n_fail++; $display("FAIL basic_tv_count: got %0d, want 1", tv_cnt); end
  endtask

  task automatic test_negative();
    bit ok;
    lat_max = 2; lsb_b = 8'hF0; msb_b = 8'hFF;
    clear_mon();
    pulse_start();
    wait_tv(3000, ok);
    n_cmp++;
    if (ok !== 1'b1) begin n_fail++; $display("FAIL neg_timeout: got no temp_vld, want one"); end
    n_cmp++;
    if (temp !== 16'hFFF0) begin n_fail++; $display("FAIL neg_temp: got %h, want fff0", temp); end
    n_cmp++;
    if (busy !== 1'b1) begin n_fail++; $display("FAIL neg_busy_at_vld: got %b, want 1", busy); end
    start = 1'b1;  // lands in the DONE cycle
    @(negedge clk);
    start = 1'b0;
    n_cmp++;
    if ({busy, temp_vld} !== 2'b00) begin n_fail++; $display("FAIL neg_busy_drop: got %b, want 00", {busy, temp_vld}); end
    repeat (20) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || req_log.size() !== 8)
      begin n_fail++; $display("FAIL done_start_ignored: got busy=%b reqs=%0d, want busy=0 reqs=8", busy, req_log.size()); end
    n_cmp++;
    if (tv_cnt !== 1 || temp !== 16'hFFF0)
      begin n_fail++; $display("FAIL neg_hold: got count=%0d temp=%h, want 1 fff0", tv_cnt, temp); end
  endtask

  task automatic test_stall();
    bit ok;
    logic [15:0] want;
    for (int it = 0; it < 3; it++) begin
      lat_max = 20;
      lsb_b = 8'($urandom); msb_b = 8'($urandom);
      want = {msb_b, lsb_b};
      clear_mon();
      pulse_start();
      wait_tv(5000, ok);
      n_cmp++;
      if (ok !== 1'b1 || temp !== want)
        begin n_fail++; $display("FAIL stall_temp[%0d]: got ok=%b temp=%h, want ok=1 temp=%h", it, ok, temp, want); end
      n_cmp++;
      if (seq_errors() !== 0) begin n_fail++; $display("FAIL stall_seq[%0d]: got %0d errors, want 0", it, seq_errors()); end
      n_cmp++;
      if (viol !== 0) begin n_fail++; $display("FAIL stall_handshake[%0d]: got %0d violations, want 0", it, viol); end
      repeat (3) @(negedge clk);
    end
  endtask

  task automatic test_busy_start();
    bit ok;
    logic [15:0] want;
    lat_max = 3;
    lsb_b = 8'($urandom); msb_b = 8'($urandom);
    want = {msb_b, lsb_b};
    clear_mon();
    pulse_start();
    wait_log(3, 500, ok);
    repeat (20) @(negedge clk);  // well inside the conversion wait
    pulse_start();
    spur_data = 8'h5A; spur_vld = 1'b1;
    @(negedge clk);
    spur_vld = 1'b0;
    wait_log(7, 1000, ok);
    n_cmp++;
    if (ok !== 1'b1) begin n_fail++; $display("FAIL busy_reach_rd: got %0d reqs, want 7", req_log.size()); end
    pulse_start();
    wait_tv(2000, ok);
    n_cmp++;
    if (ok !== 1'b1 || temp !== want)
      begin n_fail++; $display("FAIL busy_temp: got ok=%b temp=%h, want ok=1 temp=%h", ok, temp, want); end
    repeat (300) @(negedge clk);
    n_cmp++;
    if (tv_cnt !== 1 || req_log.size() !== 8 || busy !== 1'b0)
      begin n_fail++; $display("FAIL busy_ignored: got vld=%0d reqs=%0d busy=%b, want 1 8 0", tv_cnt, req_log.size(), busy); end
  endtask

  task automatic test_reset_mid();
    bit ok;
    logic [15:0] want;
    lat_max = 1;
    clear_mon();
    pulse_start();
    ok = 0;
    for (int i = 0; i < 500; i++) begin
      @(negedge clk);
      #1;
      if (conv_end_cyc >= 0) begin ok = 1; break; end
    end
    n_cmp++;
    if (ok !== 1'b1) begin n_fail++; $display("FAIL mid_reach_wait: got no CONV completion, want one"); end
    // Counter reads 50 during the cycle 51 samples after the CONV-ending sample.
    for (int i = 0; i < 200 && cyc < conv_end_cyc + 51; i++) @(negedge clk);
    rst_n = 1'b0;
    #1;
    n_cmp++;
    if ({busy, rst_en, wr_en, rd_en, temp_vld, wdata, temp} !== 29'h0)
      begin n_fail++; $display("FAIL mid_reset_outputs: got %h, want 0", {busy, rst_en, wr_en, rd_en, temp_vld, wdata, temp}); end
    @(negedge clk);
    rst_n = 1'b1;
    repeat (150) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0 || req_log.size() !== 3)
      begin n_fail++; $display("FAIL mid_idle: got busy=%b reqs=%0d, want 0 3", busy, req_log.size()); end
    lsb_b = 8'($urandom); msb_b = 8'($urandom);
    want = {msb_b, lsb_b};
    clear_mon();
    pulse_start();
    wait_tv(3000, ok);
    n_cmp++;
    if (ok !== 1'b1 || temp !== want)
      begin n_fail++; $display("FAIL mid_rerun_temp: got ok=%b temp=%h, want ok=1 temp=%h", ok, temp, want); end
    n_cmp++;
    if (seq_errors() !== 0 || viol !== 0)
      begin n_fail++; $display("FAIL mid_rerun_seq: got %0d seq errors %0d violations, want 0 0", seq_errors(), viol); end
  endtask

  initial begin
    rst_n = 1'b0; start = 1'b0; spur_vld = 1'b0; spur_data = 8'h00;
    lsb_b = 8'h00; msb_b = 8'h00;
    clear_mon();
    test_reset();
    test_basic();
    test_negative();
    test_stall();
    test_busy_start();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
